apb_i2c_bridge_fifo: RTL and testbench

Parametrised APB slave bridge between the system APB bus and the I2C core. It buffers transmit and receive data in internal FIFOs, holds the I2C configuration and timeout registers, and reports status through a readable register. Every transfer has one wait state through a registered handshake FSM. It also provides maskable interrupts and optional protocol-error reporting on PSLVERR.

---
 rtl/apb_i2c_bridge_fifo.sv | 193 +++++++++++++++++++
 tb/tb_apb_i2c_bridge_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_bridge_fifo.sv
// APB slave bridge to an I2C core: TX/RX FIFOs, CONFIG/TIMEOUT/INT_EN registers, sticky status.
// Define APB_I2C_SLVERR_EN to report protocol errors on PSLVERR; otherwise such accesses are silently ignored.
module apb_i2c_bridge_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CFG_W      = 14,
  parameter int TMO_W      = 14
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  input  logic              ERROR,
  output logic [CFG_W-1:0]  I2C_CONFIG,
  output logic [TMO_W-1:0]  I2C_TIMEOUT,
  output logic              INT_TX,
  output logic              INT_RX,
  output logic              INT_ERR,
  output logic [1:0]        o_fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // APB handshake: a transfer is SETUP -> WAIT -> ACCESS; PREADY is high only in ACCESS.
  // All side effects commit on the edge leaving WAIT, while the master still holds the bus.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_ACCESS} state_t;
  state_t r_state, w_next;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (PSELx && !PENABLE) w_next = S_SETUP;
      S_SETUP:  if (!PSELx) w_next = S_IDLE;
                else if (PENABLE) w_next = S_WAIT;
      S_WAIT:   w_next = S_ACCESS;
      S_ACCESS: w_next = (PSELx && !PENABLE) ? S_SETUP : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign o_fsm_state = r_state;

  logic w_commit, w_hi_ok;
  logic w_sel_tx, w_sel_rx, w_sel_cfg, w_sel_tmo, w_sel_st, w_sel_ien, w_sel_clr, w_mapped;
  assign w_commit  = (r_state == S_WAIT);
  assign w_hi_ok   = (PADDR[31:8] == 24'h0);
  assign w_sel_tx  = w_hi_ok && (PADDR[7:0] == 8'h00);
  assign w_sel_rx  = w_hi_ok && (PADDR[7:0] == 8'h04);
  assign w_sel_cfg = w_hi_ok && (PADDR[7:0] == 8'h08);
  assign w_sel_tmo = w_hi_ok && (PADDR[7:0] == 8'h0C);
  assign w_sel_st  = w_hi_ok && (PADDR[7:0] == 8'h10);
  assign w_sel_ien = w_hi_ok && (PADDR[7:0] == 8'h14);
  assign w_sel_clr = w_hi_ok && (PADDR[7:0] == 8'h18);
  assign w_mapped  = w_sel_tx | w_sel_rx | w_sel_cfg | w_sel_tmo | w_sel_st | w_sel_ien | w_sel_clr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [PW-1:0]     w_tx_level, w_rx_level;
  logic              w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_ovf_set;

  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]) && (r_tx_wr[AW] != r_tx_rd[AW]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]) && (r_rx_wr[AW] != r_rx_rd[AW]);
  assign w_tx_level = r_tx_wr - r_tx_rd;
  assign w_rx_level = r_rx_wr - r_rx_rd;

  assign w_tx_push = w_commit & PWRITE & w_sel_tx & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & TX_READY;
  assign w_rx_push = RX_VALID & ~w_rx_full;
  assign w_ovf_set = RX_VALID & w_rx_full;
  assign w_rx_pop  = w_commit & ~PWRITE & w_sel_rx & ~w_rx_empty;

  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= PWDATA;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= RX_DATA;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PW'(1);
      if (w_rx_push) r_rx_wr <= r_rx_wr + PW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PW'(1);
    end
  end

  assign TX_VALID = ~w_tx_empty;
  assign TX_DATA  = w_tx_empty ? '0 : r_tx_mem[r_tx_rd[AW-1:0]];

  logic [CFG_W-1:0] r_cfg;
  logic [TMO_W-1:0] r_tmo;
  logic [2:0]       r_inten;
  logic             r_rx_ovf, r_core_err;
  logic             w_clr_ovf, w_clr_err;

  assign w_clr_ovf = w_commit & PWRITE & w_sel_clr & PWDATA[4];
  assign w_clr_err = w_commit & PWRITE & w_sel_clr & PWDATA[5];

  // Sticky bits: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cfg      <= '0;
      r_tmo      <= '0;
      r_inten    <= '0;
      r_rx_ovf   <= 1'b0;
      r_core_err <= 1'b0;
    end else begin
      if (w_commit & PWRITE & w_sel_cfg) r_cfg   <= PWDATA[CFG_W-1:0];
      if (w_commit & PWRITE & w_sel_tmo) r_tmo   <= PWDATA[TMO_W-1:0];
      if (w_commit & PWRITE & w_sel_ien) r_inten <= PWDATA[2:0];
      r_rx_ovf   <= w_ovf_set | (r_rx_ovf & ~w_clr_ovf);
      r_core_err <= ERROR | (r_core_err & ~w_clr_err);
    end
  end

  assign I2C_CONFIG  = r_cfg;
  assign I2C_TIMEOUT = r_tmo;
  assign INT_TX  = r_inten[0] & w_tx_empty;
  assign INT_RX  = r_inten[1] & ~w_rx_empty;
  assign INT_ERR = r_inten[2] & (r_rx_ovf | r_core_err);

  logic [DATA_W-1:0] w_status, w_rdata;
  assign w_status = DATA_W'({8'(w_rx_level), 8'(w_tx_level), 2'b00, r_core_err, r_rx_ovf,
                             w_rx_full, w_rx_empty, w_tx_full, w_tx_empty});

  always_comb begin
    w_rdata = '0;
    if (!PWRITE) begin
      if (w_sel_rx && !w_rx_empty) w_rdata = r_rx_mem[r_rx_rd[AW-1:0]];
      if (w_sel_cfg)               w_rdata = DATA_W'(r_cfg);
      if (w_sel_tmo)               w_rdata = DATA_W'(r_tmo);
      if (w_sel_st)                w_rdata = w_status;
      if (w_sel_ien)               w_rdata = DATA_W'(r_inten);
    end
  end

  logic w_err;
`ifdef APB_I2C_SLVERR_EN
  assign w_err = ~w_mapped
               | (PWRITE & w_sel_tx & w_tx_full)
               | (~PWRITE & w_sel_rx & w_rx_empty)
               | (PWRITE & (w_sel_rx | w_sel_st))
               | (~PWRITE & (w_sel_tx | w_sel_clr));
`else
  assign w_err = 1'b0;
`endif

  logic [DATA_W-1:0] r_prdata;
  logic              r_pready, r_pslverr;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= w_commit;
      r_pslverr <= w_commit & w_err & w_mapped | w_commit & w_err & ~w_mapped;
      if (w_commit) r_prdata <= w_rdata;
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_i2c_bridge_fifo.sv
// Bench for apb_i2c_bridge_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_apb_i2c_bridge_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CFG_W  = 14;
  localparam int TMO_W  = 14;
`ifdef APB_I2C_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic              PCLK, PRESETn, PSELx, PENABLE, PWRITE;
  logic [31:0]       PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA, TX_DATA, RX_DATA;
  logic              PREADY, PSLVERR, TX_VALID, TX_READY, RX_VALID, ERROR;
  logic [CFG_W-1:0]  I2C_CONFIG;
  logic [TMO_W-1:0]  I2C_TIMEOUT;
  logic              INT_TX, INT_RX, INT_ERR;
  logic [1:0]        fsm_state;

  apb_i2c_bridge_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CFG_W(CFG_W), .TMO_W(TMO_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .ERROR(ERROR), .I2C_CONFIG(I2C_CONFIG), .I2C_TIMEOUT(I2C_TIMEOUT),
    .INT_TX(INT_TX), .INT_RX(INT_RX), .INT_ERR(INT_ERR), .o_fsm_state(fsm_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // reference model
  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] rx_q[$];
  logic [CFG_W-1:0]  m_cfg;
  logic [TMO_W-1:0]  m_tmo;
  logic [2:0]        m_inten;
  bit                m_ovf, m_cerr;
  int                n_cmp, n_bad;
  bit                wait_tx_ready, wait_error;
  logic [DATA_W-1:0] last_rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_cfg = '0; m_tmo = '0; m_inten = '0; m_ovf = 0; m_cerr = 0;
  endtask

  function automatic logic [DATA_W-1:0] m_status();
    logic [DATA_W-1:0] s;
    s = '0;
    s[0] = (tx_q.size() == 0);
    s[1] = (tx_q.size() == DEPTH);
    s[2] = (rx_q.size() == 0);
    s[3] = (rx_q.size() == DEPTH);
    s[4] = m_ovf;
    s[5] = m_cerr;
    s[15:8]  = 8'(tx_q.size());
    s[23:16] = 8'(rx_q.size());
    return s;
  endfunction

  // Effect of one APB transfer plus any core event on the same edge, from pre-edge state.
  task automatic model_apb(input bit wr, input logic [31:0] a, input logic [DATA_W-1:0] d,
                           input bit core_pop, input bit core_err_ev,
                           output logic [DATA_W-1:0] rd, output bit err);
    bit tx_full0, tx_empty0, push;
    err = 0; rd = '0; push = 0;
    tx_full0  = (tx_q.size() == DEPTH);
    tx_empty0 = (tx_q.size() == 0);
    if (a[31:8] != 24'h0) err = 1;
    else begin
      case (a[7:0])
        8'h00: if (wr) begin if (tx_full0) err = 1; else push = 1; end else err = 1;
        8'h04: if (wr) err = 1; else if (rx_q.size() == 0) err = 1; else rd = rx_q.pop_front();
        8'h08: if (wr) m_cfg = d[CFG_W-1:0]; else rd = DATA_W'(m_cfg);
        8'h0C: if (wr) m_tmo = d[TMO_W-1:0]; else rd = DATA_W'(m_tmo);
        8'h10: if (wr) err = 1; else rd = m_status();
        8'h14: if (wr) m_inten = d[2:0]; else rd = DATA_W'(m_inten);
        8'h18: if (wr) begin if (d[4]) m_ovf = 0; if (d[5]) m_cerr = 0; end else err = 1;
        default: err = 1;
      endcase
    end
    if (core_err_ev) m_cerr = 1;
    if (core_pop && !tx_empty0) void'(tx_q.pop_front());
    if (push) tx_q.push_back(d);
    if (!SLVERR_EN) err = 0;
  endtask

  task automatic check_pins(input string tag);
    check_eq({tag, ".int_tx"},  INT_TX,  m_inten[0] & (tx_q.size() == 0));
    check_eq({tag, ".int_rx"},  INT_RX,  m_inten[1] & (rx_q.size() != 0));
    check_eq({tag, ".int_err"}, INT_ERR, m_inten[2] & (m_ovf | m_cerr));
    check_eq({tag, ".tx_valid"}, TX_VALID, tx_q.size() != 0);
    check_eq({tag, ".tx_data"}, TX_DATA, (tx_q.size() != 0) ? tx_q[0] : '0);
    check_eq({tag, ".cfg"}, I2C_CONFIG, m_cfg);
    check_eq({tag, ".tmo"}, I2C_TIMEOUT, m_tmo);
  endtask

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic apb(input bit wr, input logic [31:0] a, input logic [DATA_W-1:0] d, input string tag);
    logic [DATA_W-1:0] exp_rd;
    bit exp_err;
    int cyc;
    PSELx = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1; PENABLE = 1; cyc = 1;
    @(posedge PCLK); #1; cyc = 2;
    if (wait_tx_ready && tx_q.size() != 0) check_eq({tag, ".head"}, TX_DATA, tx_q[0]);
    TX_READY = wait_tx_ready; ERROR = wait_error;
    model_apb(wr, a, d, wait_tx_ready, wait_error, exp_rd, exp_err);
    @(posedge PCLK); #1; cyc = 3; TX_READY = 0; ERROR = 0;
    while (!PREADY && cyc < 10) begin @(posedge PCLK); #1; cyc++; end
    check_eq({tag, ".lat"}, cyc, 3);
    check_eq({tag, ".slverr"}, PSLVERR, exp_err);
    if (!wr) check_eq({tag, ".rdata"}, PRDATA, exp_rd);
    last_rd = PRDATA;
    PSELx = 0; PENABLE = 0; wait_tx_ready = 0; wait_error = 0;
    @(posedge PCLK); #1;
    check_eq({tag, ".pready_low"}, PREADY, 0);
  endtask

  task automatic core_rx(input logic [DATA_W-1:0] d);
    RX_VALID = 1; RX_DATA = d;
    @(posedge PCLK); #1; RX_VALID = 0;
    if (rx_q.size() == DEPTH) m_ovf = 1; else rx_q.push_back(d);
  endtask

  task automatic core_tx_pop();
    TX_READY = 1;
    @(posedge PCLK); #1; TX_READY = 0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic core_error();
    ERROR = 1;
    @(posedge PCLK); #1; ERROR = 0;
    m_cerr = 1;
  endtask

  task automatic drain(input string tag);
    TX_READY = 1;
    while (tx_q.size() != 0) begin
      check_eq({tag, ".data"}, TX_DATA, tx_q[0]);
      void'(tx_q.pop_front());
      @(posedge PCLK); #1;
    end
    TX_READY = 0;
    check_eq({tag, ".valid_end"}, TX_VALID, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".prdata"}, PRDATA, 0);
    check_eq({tag, ".ctl"}, {PREADY, PSLVERR, TX_VALID, INT_TX, INT_RX, INT_ERR}, 0);
    check_eq({tag, ".txdata"}, TX_DATA, 0);
    check_eq({tag, ".regs"}, {I2C_CONFIG, I2C_TIMEOUT}, 0);
    check_eq({tag, ".fsm"}, fsm_state, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; wait_tx_ready = 0; wait_error = 0;
    PRESETn = 0; PSELx = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    TX_READY = 0; RX_DATA = '0; RX_VALID = 0; ERROR = 0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1; PRESETn = 1;
    @(posedge PCLK); #1;
    check_all_zero("rst");

    // reset mid-transfer
    apb(1, 32'h08, 32'h3FFF, "rst.cfg");
    check_eq("rst.cfg_pin", I2C_CONFIG, 14'h3FFF);
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h0C; PWDATA = 32'h55;
    @(posedge PCLK); #1; PENABLE = 1;
    @(posedge PCLK); #1; PRESETn = 0;
    #1; check_all_zero("rst.abort");
    PSELx = 0; PENABLE = 0; model_reset();
    @(posedge PCLK); #1; PRESETn = 1;
    @(posedge PCLK); #1;
    apb(0, 32'h0C, '0, "rst.tmo_rd");
    apb(0, 32'h08, '0, "rst.cfg_rd");
    check_pins("rst.pins");

    // TX FIFO fill past full, then drain
    for (int i = 0; i < DEPTH + 1; i++) apb(1, 32'h00, DATA_W'(32'h100 + i), "tx.wr");
    apb(0, 32'h10, '0, "tx.status");
    check_eq("tx.full_bit", last_rd[1], 1);
    check_eq("tx.level", last_rd[15:8], 8);
    check_pins("tx.pins");
    drain("tx.drain");

    // RX overflow and W1C
    apb(1, 32'h14, 32'h4, "rx.inten");
    for (int i = 0; i < DEPTH + 1; i++) core_rx(DATA_W'(32'hA00 + i));
    check_eq("rx.int_err_on", INT_ERR, 1);
    apb(0, 32'h10, '0, "rx.status");
    for (int i = 0; i < DEPTH + 1; i++) apb(0, 32'h04, '0, "rx.rd");
    apb(1, 32'h18, 32'h10, "rx.clr");
    check_eq("rx.int_err_off", INT_ERR, 0);
    check_pins("rx.pins");

    // simultaneous push/pop and set-vs-clear
    for (int i = 0; i < 3; i++) apb(1, 32'h00, DATA_W'(32'h200 + i), "sim.wr");
    wait_tx_ready = 1;
    apb(1, 32'h00, 32'h203, "sim.both");
    apb(0, 32'h10, '0, "sim.status");
    check_eq("sim.level", last_rd[15:8], 3);
    drain("sim.drain");
    wait_error = 1;
    apb(1, 32'h18, 32'h20, "sim.errclr");
    apb(0, 32'h10, '0, "sim.err_status");
    check_eq("sim.core_err_kept", last_rd[5], 1);
    apb(1, 32'h18, 32'h20, "sim.errclr2");
    apb(0, 32'h10, '0, "sim.err_status2");

    // config registers
    apb(1, 32'h08, 32'hFFFF_FFFF, "cfg.wr");
    apb(1, 32'h0C, 32'h1234, "tmo.wr");
    check_eq("cfg.pin", I2C_CONFIG, 14'h3FFF);
    check_eq("tmo.pin", I2C_TIMEOUT, 14'h1234);
    apb(0, 32'h08, '0, "cfg.rd");
    apb(0, 32'h0C, '0, "tmo.rd");
    apb(0, 32'h10, '0, "cfg.status");

    // protocol-error accesses
    apb(1, 32'h1C, 32'hDEAD, "err.unmapped_wr");
    apb(1, 32'h108, 32'h1, "err.hi_addr_wr");
    apb(0, 32'h04, '0, "err.rx_empty_rd");
    apb(1, 32'h10, 32'hFF, "err.status_wr");
    apb(0, 32'h18, '0, "err.clr_rd");
    apb(0, 32'h10, '0, "err.status");
    check_pins("err.pins");

    // random traffic
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1: apb(1, 32'h00, DATA_W'($urandom), "rnd.txwr");
        2:    apb(0, 32'h04, '0, "rnd.rxrd");
        3:    core_rx(DATA_W'($urandom));
        4:    core_tx_pop();
        5:    apb(0, 32'h10, '0, "rnd.status");
        6:    apb($urandom_range(0, 1), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                  DATA_W'($urandom), "rnd.any");
        7:    begin
                wait_tx_ready = $urandom_range(0, 1);
                wait_error = $urandom_range(0, 1);
                apb(1, 32'h18, DATA_W'($urandom_range(0, 3) << 4), "rnd.clr");
              end
        8:    apb(1, 32'h14, DATA_W'($urandom_range(0, 7)), "rnd.inten");
        default: if ($urandom_range(0, 3) == 0) core_error(); else core_rx(DATA_W'($urandom));
      endcase
      check_pins("rnd.pins");
    end
    apb(0, 32'h10, '0, "end.status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

●
